// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg_if
// Description : Bundle interface between the decode-stage control unit and
//               the ID/EX pipeline register. Carries the pipeline controls
//               (freeze/flush/bubble), every decoded *_in field, and the
//               registered *_out fields, valid flag and bubble counter.
//   master : drives controls and *_in, observes *_out (upstream / bench)
//   slave  : consumes controls and *_in, drives *_out (the ID/EX register)
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_reg_if #(
  parameter int CNT_W = 16
);
  // Pipeline controls
  logic             freeze;
  logic             flush;
  logic             bubble;

  // Decode-side fields
  logic [31:0]      PC_in;
  logic [3:0]       EXE_CMD_in;
  logic             WB_EN_in;
  logic             MEM_R_EN_in;
  logic             MEM_W_EN_in;
  logic             B_in;
  logic             S_in;
  logic [31:0]      Val_Rn_in;
  logic [31:0]      Val_Rm_in;
  logic             imm_in;
  logic [11:0]      Shift_operand_in;
  logic [23:0]      Signed_imm_24_in;
  logic [3:0]       Dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic [3:0]       SR_in;

  // Execute-side registered fields
  logic [31:0]      PC_out;
  logic [3:0]       EXE_CMD_out;
  logic             WB_EN_out;
  logic             MEM_R_EN_out;
  logic             MEM_W_EN_out;
  logic             B_out;
  logic             S_out;
  logic [31:0]      Val_Rn_out;
  logic [31:0]      Val_Rm_out;
  logic             imm_out;
  logic [11:0]      Shift_operand_out;
  logic [23:0]      Signed_imm_24_out;
  logic [3:0]       Dest_out;
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;
  logic [3:0]       SR_out;
  logic             valid_out;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, flush, bubble,
    output PC_in, EXE_CMD_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
    output Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    output Dest_in, src1_in, src2_in, SR_in,
    input  PC_out, EXE_CMD_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out,
    input  Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    input  Dest_out, src1_out, src2_out, SR_out, valid_out, bubble_cnt
  );

  modport slave (
    input  freeze, flush, bubble,
    input  PC_in, EXE_CMD_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
    input  Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    input  Dest_in, src1_in, src2_in, SR_in,
    output PC_out, EXE_CMD_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out,
    output Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    output Dest_out, src1_out, src2_out, SR_out, valid_out, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register. Captures the decoded control bundle
//               and operand fields every edge, with freeze (hold), flush
//               (clear everything) and bubble (clear control, keep data).
//               Keeps a saturating count of flush/bubble insertions.
// Ports       :
//   clk  - pipeline clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - id_ex_reg_if.slave: freeze/flush/bubble, *_in fields in,
//          *_out fields, valid_out and bubble_cnt out
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  wire          clk,
  input  wire          rst,
  id_ex_reg_if.slave   bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  exe_cmd;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bundle_t          w_in;
  bundle_t          bundle_d, bundle_q;
  logic             valid_d,  valid_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;

  // Gather the interface inputs into one bundle.
  always_comb begin
    w_in               = '0;
    w_in.pc            = bus.PC_in;
    w_in.exe_cmd       = bus.EXE_CMD_in;
    w_in.wb_en         = bus.WB_EN_in;
    w_in.mem_r_en      = bus.MEM_R_EN_in;
    w_in.mem_w_en      = bus.MEM_W_EN_in;
    w_in.b             = bus.B_in;
    w_in.s             = bus.S_in;
    w_in.val_rn        = bus.Val_Rn_in;
    w_in.val_rm        = bus.Val_Rm_in;
    w_in.imm           = bus.imm_in;
    w_in.shift_operand = bus.Shift_operand_in;
    w_in.signed_imm_24 = bus.Signed_imm_24_in;
    w_in.dest          = bus.Dest_in;
    w_in.src1          = bus.src1_in;
    w_in.src2          = bus.src2_in;
    w_in.sr            = bus.SR_in;
  end

  // Next-state: freeze > flush > bubble > load. Flush and bubble together
  // take the flush branch, so the counter only steps once.
  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (!bus.freeze) begin
      if (bus.flush) begin
        bundle_d = '0;
        valid_d  = 1'b0;
      end else if (bus.bubble) begin
        // Data still loads so forwarding logic sees the real source regs;
        // only the side-effecting control bits are squashed.
        bundle_d          = w_in;
        bundle_d.exe_cmd  = '0;
        bundle_d.wb_en    = 1'b0;
        bundle_d.mem_r_en = 1'b0;
        bundle_d.mem_w_en = 1'b0;
        bundle_d.b        = 1'b0;
        bundle_d.s        = 1'b0;
        valid_d           = 1'b0;
      end else begin
        bundle_d = w_in;
        valid_d  = 1'b1;
      end
      if ((bus.flush || bus.bubble) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset overrides freeze, so it sits outside the hold logic above.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.PC_out            = bundle_q.pc;
  assign bus.EXE_CMD_out       = bundle_q.exe_cmd;
  assign bus.WB_EN_out         = bundle_q.wb_en;
  assign bus.MEM_R_EN_out      = bundle_q.mem_r_en;
  assign bus.MEM_W_EN_out      = bundle_q.mem_w_en;
  assign bus.B_out             = bundle_q.b;
  assign bus.S_out             = bundle_q.s;
  assign bus.Val_Rn_out        = bundle_q.val_rn;
  assign bus.Val_Rm_out        = bundle_q.val_rm;
  assign bus.imm_out           = bundle_q.imm;
  assign bus.Shift_operand_out = bundle_q.shift_operand;
  assign bus.Signed_imm_24_out = bundle_q.signed_imm_24;
  assign bus.Dest_out          = bundle_q.dest;
  assign bus.src1_out          = bundle_q.src1;
  assign bus.src2_out          = bundle_q.src2;
  assign bus.SR_out            = bundle_q.sr;
  assign bus.valid_out         = valid_q;
  assign bus.bubble_cnt        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Scoreboard bench for id_ex_reg (CNT_W=4). The driver applies
//               one directed vector per cycle and pushes the hand-chosen
//               expected response; a monitor pops and compares after each
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

  localparam int CNT_W = 4;
  localparam int K_LOAD = 0, K_BUB = 1, K_ZERO = 2, K_HOLD = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  exe_cmd;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } bundle_t;

  typedef struct packed {
    bundle_t          b;
    logic             v;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  last_e;

  id_ex_reg_if #(.CNT_W(CNT_W)) bus ();

  id_ex_reg #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Nonzero, seed-distinct field values.
  function automatic bundle_t base(input int n);
    bundle_t r;
    r.pc            = 32'h1000_0000 + n;
    r.exe_cmd       = 4'(n + 1);
    r.wb_en         = 1'b1;
    r.mem_r_en      = 1'b1;
    r.mem_w_en      = 1'b1;
    r.b             = 1'b1;
    r.s             = 1'b1;
    r.val_rn        = 32'hA000_0000 + n;
    r.val_rm        = 32'hB000_0000 + n;
    r.imm           = 1'b1;
    r.shift_operand = 12'(12'h800 + n);
    r.signed_imm_24 = 24'(24'h40_0000 + n);
    r.dest          = 4'(n + 2);
    r.src1          = 4'(n + 3);
    r.src2          = 4'(n + 4);
    r.sr            = 4'(n + 5);
    return r;
  endfunction

  task automatic step(input logic r, input logic fz, input logic fl, input logic bb,
                      input bundle_t din, input int kind,
                      input logic [CNT_W-1:0] cnt, input string name);
    exp_t e;
    rst                  = r;
    bus.freeze           = fz;
    bus.flush            = fl;
    bus.bubble           = bb;
    bus.PC_in            = din.pc;
    bus.EXE_CMD_in       = din.exe_cmd;
    bus.WB_EN_in         = din.wb_en;
    bus.MEM_R_EN_in      = din.mem_r_en;
    bus.MEM_W_EN_in      = din.mem_w_en;
    bus.B_in             = din.b;
    bus.S_in             = din.s;
    bus.Val_Rn_in        = din.val_rn;
    bus.Val_Rm_in        = din.val_rm;
    bus.imm_in           = din.imm;
    bus.Shift_operand_in = din.shift_operand;
    bus.Signed_imm_24_in = din.signed_imm_24;
    bus.Dest_in          = din.dest;
    bus.src1_in          = din.src1;
    bus.src2_in          = din.src2;
    bus.SR_in            = din.sr;
    e = '0;
    case (kind)
      K_LOAD: begin e.b = din; e.v = 1'b1; end
      K_BUB: begin
        e.b = din;
        e.b.exe_cmd = 4'd0; e.b.wb_en = 1'b0; e.b.mem_r_en = 1'b0;
        e.b.mem_w_en = 1'b0; e.b.b = 1'b0; e.b.s = 1'b0;
        e.v = 1'b0;
      end
      K_HOLD: begin e.b = last_e.b; e.v = last_e.v; end
      default: begin e.b = '0; e.v = 1'b0; end
    endcase
    e.c = cnt;
    last_e = e;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: the register presents a new bundle after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      bundle_t a;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.pc = bus.PC_out; a.exe_cmd = bus.EXE_CMD_out; a.wb_en = bus.WB_EN_out;
      a.mem_r_en = bus.MEM_R_EN_out; a.mem_w_en = bus.MEM_W_EN_out;
      a.b = bus.B_out; a.s = bus.S_out; a.val_rn = bus.Val_Rn_out;
      a.val_rm = bus.Val_Rm_out; a.imm = bus.imm_out;
      a.shift_operand = bus.Shift_operand_out; a.signed_imm_24 = bus.Signed_imm_24_out;
      a.dest = bus.Dest_out; a.src1 = bus.src1_out; a.src2 = bus.src2_out;
      a.sr = bus.SR_out;
      checks++;
      if (a !== e.b) begin
        failures++;
        $display("FAIL %s fields actual=%h required=%h", n, a, e.b);
      end
      checks++;
      if (bus.valid_out !== e.v) begin
        failures++;
        $display("FAIL %s valid_out actual=%b required=%b", n, bus.valid_out, e.v);
      end
      checks++;
      if (bus.bubble_cnt !== e.c) begin
        failures++;
        $display("FAIL %s bubble_cnt actual=%0d required=%0d", n, bus.bubble_cnt, e.c);
      end
    end
  end

  initial begin
    bundle_t v;
    // Reset with every input nonzero, including the pipeline controls.
    step(1, 0, 0, 0, base(1), K_ZERO, 0, "reset0");
    step(1, 1, 1, 1, base(2), K_ZERO, 0, "reset1");
    v = '0; v.exe_cmd = 4'b0010; v.wb_en = 1'b1; v.dest = 4'd5;
    step(0, 0, 0, 0, v, K_LOAD, 0, "first_load");
    // Normal stream
    v = base(3); v.pc = 32'd4;  step(0, 0, 0, 0, v, K_LOAD, 0, "stream_pc4");
    v = base(4); v.pc = 32'd8;  step(0, 0, 0, 0, v, K_LOAD, 0, "stream_pc8");
    v = base(5); v.pc = 32'd12; step(0, 0, 0, 0, v, K_LOAD, 0, "stream_pc12");
    // LDR then freeze x3 with flush pending and changing inputs
    v = '0; v.mem_r_en = 1'b1; v.wb_en = 1'b1; v.val_rn = 32'h100; v.dest = 4'd7;
    v.pc = 32'd16;
    step(0, 0, 0, 0, v, K_LOAD, 0, "ldr");
    step(0, 1, 1, 0, base(8),  K_HOLD, 0, "freeze1");
    step(0, 1, 1, 0, base(9),  K_HOLD, 0, "freeze2");
    step(0, 1, 1, 1, base(10), K_HOLD, 0, "freeze3");
    step(0, 0, 1, 0, base(11), K_ZERO, 1, "flush_after_freeze");
    // Bubble keeps data, clears control
    v = base(12); v.src1 = 4'd3; v.wb_en = 1'b1;
    step(0, 0, 0, 1, v, K_BUB, 2, "bubble");
    // Flush and bubble together: flush wins, one increment
    step(0, 0, 1, 1, base(13), K_ZERO, 3, "flush_bubble");
    step(0, 0, 0, 0, base(14), K_LOAD, 3, "normal");
    step(0, 1, 0, 1, base(15), K_HOLD, 3, "freeze_bubble");
    // Saturation: counter climbs from 3 and sticks at 15
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, base(16 + i), K_BUB, ((4 + i) > 15) ? 4'd15 : 4'(4 + i), "saturate");
    end
    step(0, 0, 1, 0, base(40), K_ZERO, 15, "flush_saturated");
    // Reset during freeze
    step(1, 1, 1, 1, base(41), K_ZERO, 0, "reset_freeze");
    step(0, 0, 0, 0, base(42), K_LOAD, 0, "post_reset");
    rst = 1'b0; bus.freeze = 1'b1; bus.flush = 1'b0; bus.bubble = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
